// File: rtl/ts_channel_scheduler.sv
// ts_channel_scheduler
// ---------------------------------------------------------------------------
// Packet-boundary round-robin scheduler for four MPEG2-TS input channels.
// One channel at a time owns the shared output path. Ownership is handed over
// only between whole PKT_LEN-byte packets, so the output stream is never
// spliced in the middle of a packet.
//
// Optional feature macro: SCHED_TIMEOUT_EN
//   defined   : a stall counter aborts an owner that presents no byte for
//               TIMEOUT_CYC clocks (pulses timeout, returns to IDLE).
//   undefined : no stall counter, timeout is tied 0, a stalled owner keeps
//               the output indefinitely.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   req[3:0]   in   channel i has at least one packet ready
//   valid[3:0] in   channel i presents a byte this cycle
//   sync[3:0]  in   channel i's current byte is a sync byte (with valid[i])
//   mux_ctrl   out  selected channel index (registered)
//   grant[3:0] out  one-hot of mux_ctrl while a channel is owned, 0 in IDLE
//   pkt_active out  high while a packet is being transferred
//   pkt_done   out  one-cycle pulse after the last byte of a packet
//   sync_err   out  one-cycle pulse after an unexpected sync inside a packet
//   timeout    out  one-cycle pulse after a stall abort
// ---------------------------------------------------------------------------
module ts_channel_scheduler #(
   parameter int PKT_LEN     = 188,
   parameter int CNT_W       = 8,
   parameter int TIMEOUT_CYC = 1024,
   parameter int TO_W        = 11
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] req,
   input  logic [3:0] valid,
   input  logic [3:0] sync,
   output logic [1:0] mux_ctrl,
   output logic [3:0] grant,
   output logic       pkt_active,
   output logic       pkt_done,
   output logic       sync_err,
   output logic       timeout
);

   localparam logic [1:0] IDLE      = 2'd0;
   localparam logic [1:0] WAIT_SYNC = 2'd1;
   localparam logic [1:0] XFER      = 2'd2;

   // Counter widths must be able to hold their terminal values.
   generate
      if ((2 ** CNT_W) <= PKT_LEN || (2 ** TO_W) <= TIMEOUT_CYC) begin : g_bad_cfg
         $error("ts_channel_scheduler: counter width too small for PKT_LEN/TIMEOUT_CYC");
      end
   endgenerate

   logic [1:0]       state_reg, state_next;
   logic [1:0]       sel_reg, sel_next;
   logic [1:0]       last_reg, last_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic             done_reg, done_next;
   logic             err_reg, err_next;

   // Round-robin candidates in priority order: last+1, last+2, last+3, last+4
   // (the last one wraps to the previous owner itself, so a lone requester is
   // re-granted).
   logic [1:0] cand_idx [4];
   logic [3:0] cand_hit;
   logic [1:0] pick;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_cand
         assign cand_idx[gi] = last_reg + 2'(gi + 1);
         assign cand_hit[gi] = req[cand_idx[gi]];
      end
   endgenerate

   always_comb begin
      pick = cand_idx[3];
      for (int k = 3; k >= 0; k--) begin
         if (cand_hit[k]) pick = cand_idx[k];
      end
   end

   // Only the owning channel's lane is ever looked at.
   logic sel_valid, sel_sync;
   assign sel_valid = valid[sel_reg];
   assign sel_sync  = sync[sel_reg];

`ifdef SCHED_TIMEOUT_EN
   logic [TO_W-1:0] stall_reg, stall_next;
   logic            to_reg, to_next;
`endif

   always_comb begin
      state_next = state_reg;
      sel_next   = sel_reg;
      last_next  = last_reg;
      cnt_next   = cnt_reg;
      done_next  = 1'b0;
      err_next   = 1'b0;

      case (state_reg)
         IDLE: begin
            if (|req) begin
               sel_next   = pick;
               last_next  = pick;
               state_next = WAIT_SYNC;
            end
         end
         WAIT_SYNC: begin
            // Non-sync bytes before the first sync are discarded.
            if (sel_valid && sel_sync) begin
               cnt_next   = CNT_W'(1);
               state_next = XFER;
            end
         end
         XFER: begin
            if (sel_valid) begin
               if (sel_sync && (cnt_reg != '0)) begin
                  // Early sync: treat this byte as the start of a new packet.
                  err_next = 1'b1;
                  cnt_next = CNT_W'(1);
               end else if (cnt_reg == CNT_W'(PKT_LEN - 1)) begin
                  done_next  = 1'b1;
                  cnt_next   = '0;
                  state_next = IDLE;
               end else begin
                  cnt_next = cnt_reg + CNT_W'(1);
               end
            end
         end
         default: begin
            state_next = IDLE;
            cnt_next   = '0;
         end
      endcase

`ifdef SCHED_TIMEOUT_EN
      to_next    = 1'b0;
      stall_next = stall_reg;
      if (state_reg == IDLE) begin
         // Held at zero in IDLE so every WAIT_SYNC entry starts from zero.
         stall_next = '0;
      end else if (sel_valid) begin
         stall_next = '0;
      end else if (stall_reg == TO_W'(TIMEOUT_CYC - 1)) begin
         // last_reg already points at the stalled channel, so it loses its turn.
         to_next    = 1'b1;
         stall_next = '0;
         cnt_next   = '0;
         state_next = IDLE;
      end else begin
         stall_next = stall_reg + TO_W'(1);
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         sel_reg   <= 2'd0;
         last_reg  <= 2'd3;
         cnt_reg   <= '0;
         done_reg  <= 1'b0;
         err_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         sel_reg   <= sel_next;
         last_reg  <= last_next;
         cnt_reg   <= cnt_next;
         done_reg  <= done_next;
         err_reg   <= err_next;
      end
   end

`ifdef SCHED_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_reg <= '0;
         to_reg    <= 1'b0;
      end else begin
         stall_reg <= stall_next;
         to_reg    <= to_next;
      end
   end
   assign timeout = to_reg;
`else
   assign timeout = 1'b0;
`endif

   generate
      for (gi = 0; gi < 4; gi++) begin : g_grant
         assign grant[gi] = (state_reg != IDLE) && (sel_reg == 2'(gi));
      end
   endgenerate

   assign mux_ctrl   = sel_reg;
   assign pkt_active = (state_reg == XFER);
   assign pkt_done   = done_reg;
   assign sync_err   = err_reg;

endmodule

// File: tb/tb_ts_channel_scheduler.sv
// Testbench for ts_channel_scheduler: packet-level reference model (round-robin
// pick by arithmetic search, byte counting per packet) with random noise on
// non-selected channels and random valid gaps.
module tb_ts_channel_scheduler;

   localparam int PKT_LEN     = 188;
   localparam int TIMEOUT_CYC = 1024;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] req, valid, sync;
   logic [1:0] mux_ctrl;
   logic [3:0] grant;
   logic       pkt_active, pkt_done, sync_err, timeout;

   int errors = 0;
   int checks = 0;
   int m_last = 3;   // model: most recently granted channel

   ts_channel_scheduler #(
      .PKT_LEN(PKT_LEN), .CNT_W(8), .TIMEOUT_CYC(TIMEOUT_CYC), .TO_W(11)
   ) dut (
      .clk(clk), .rst(rst), .req(req), .valid(valid), .sync(sync),
      .mux_ctrl(mux_ctrl), .grant(grant), .pkt_active(pkt_active),
      .pkt_done(pkt_done), .sync_err(sync_err), .timeout(timeout)
   );

   always #5 clk = ~clk;

   function automatic int rr_pick(int last, logic [3:0] r);
      for (int d = 1; d <= 4; d++) begin
         int c;
         c = (last + d) % 4;
         if (r[c]) return c;
      end
      return -1;
   endfunction

   function automatic logic [3:0] onehot(int ch);
      logic [3:0] v;
      v = '0;
      v[ch] = 1'b1;
      return v;
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Random activity on every channel other than the owner.
   task automatic noise(input int ch);
      for (int j = 0; j < 4; j++) begin
         if (j != ch) begin
            valid[j] = 1'($urandom_range(0, 1));
            sync[j]  = 1'($urandom_range(0, 1));
         end
      end
   endtask

   // Drives one packet on channel ch, starting in the first WAIT_SYNC cycle.
   // junk non-sync bytes precede the sync; err_at>0 places an early sync as
   // byte err_at. Returns per-cycle disagreements with the model in bad.
   task automatic drive_packet(input int ch, input int junk, input int err_at,
                               input int gap_pct, output int bad,
                               output int err_seen, output int done_ok);
      int  k, junk_left, guard;
      bit  exp_err, fin, err_used;
      bad = 0; err_seen = 0; done_ok = 0;
      k = 0; junk_left = junk; guard = 0; err_used = 0;
      forever begin
         noise(ch);
         exp_err = 0;
         fin     = 0;
         if ($urandom_range(0, 99) < gap_pct) begin
            valid[ch] = 1'b0;
            sync[ch]  = 1'($urandom_range(0, 1));
         end else if (junk_left > 0) begin
            valid[ch] = 1'b1; sync[ch] = 1'b0; junk_left--;
         end else begin
            valid[ch] = 1'b1;
            if (k == 0) begin
               sync[ch] = 1'b1; k = 1;
            end else if (err_at > 0 && !err_used && k == err_at - 1) begin
               sync[ch] = 1'b1; k = 1; exp_err = 1; err_used = 1;
            end else begin
               sync[ch] = 1'b0; k++;
            end
            fin = (k == PKT_LEN);
         end
         tick;
         if (fin) begin
            done_ok = (pkt_done === 1'b1 && grant === 4'b0 && pkt_active === 1'b0
                       && sync_err === 1'b0) ? 1 : 0;
            break;
         end
         if (mux_ctrl !== 2'(ch) || grant !== onehot(ch) || pkt_done !== 1'b0 ||
             pkt_active !== (k > 0) || sync_err !== exp_err || timeout !== 1'b0)
            bad++;
         if (sync_err === 1'b1) err_seen++;
         guard++;
         if (guard > 5000) begin
            bad++;
            break;
         end
      end
      valid = '0;
      sync  = '0;
   endtask

   task automatic test_reset;
      rst = 1'b1; req = '0; valid = '0; sync = '0;
      tick; tick;
      checks++;
      if (mux_ctrl !== 2'd0 || grant !== 4'b0 || pkt_active !== 1'b0 ||
          pkt_done !== 1'b0 || sync_err !== 1'b0 || timeout !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs: mux=%0d grant=%b act=%b done=%b err=%b to=%b expected 0/0000/0/0/0/0",
                  mux_ctrl, grant, pkt_active, pkt_done, sync_err, timeout);
      end
      rst = 1'b0; m_last = 3;
      tick; tick;
      checks++;
      if (grant !== 4'b0 || mux_ctrl !== 2'd0) begin
         errors++;
         $display("FAIL idle_hold: grant=%b mux=%0d expected 0000/0", grant, mux_ctrl);
      end
   endtask

   task automatic test_round_robin;
      int exp, bad, es, dok;
      int order[5] = '{0, 1, 2, 3, 0};
      for (int p = 0; p < 5; p++) begin
         req = 4'b1111;
         tick;
         exp = rr_pick(m_last, req);
         m_last = exp;
         checks++;
         if (grant !== onehot(order[p]) || mux_ctrl !== 2'(order[p]) || exp != order[p]) begin
            errors++;
            $display("FAIL rr_grant[%0d]: grant=%b mux=%0d expected channel %0d", p, grant, mux_ctrl, order[p]);
         end
         drive_packet(exp, 0, 0, 0, bad, es, dok);
         checks++;
         if (bad != 0 || es != 0 || dok != 1) begin
            errors++;
            $display("FAIL rr_packet[%0d]: bad_cycles=%0d sync_err=%0d done_ok=%0d expected 0/0/1", p, bad, es, dok);
         end
      end
   endtask

   task automatic test_back_to_back;
      int bad, es, dok;
      for (int p = 0; p < 2; p++) begin
         req = 4'b0100;
         tick;
         m_last = rr_pick(m_last, req);
         checks++;
         if (grant !== 4'b0100 || mux_ctrl !== 2'd2) begin
            errors++;
            $display("FAIL b2b_grant[%0d]: grant=%b mux=%0d expected 0100/2", p, grant, mux_ctrl);
         end
         drive_packet(2, 0, 0, 0, bad, es, dok);
         checks++;
         if (bad != 0 || dok != 1 || mux_ctrl !== 2'd2) begin
            errors++;
            $display("FAIL b2b_packet[%0d]: bad_cycles=%0d done_ok=%0d mux=%0d expected 0/1/2", p, bad, dok, mux_ctrl);
         end
      end
   endtask

   task automatic test_sync_err;
      int bad, es, dok;
      req = 4'b0010;
      tick;
      m_last = rr_pick(m_last, req);
      checks++;
      if (grant !== 4'b0010) begin
         errors++;
         $display("FAIL serr_grant: grant=%b expected 0010", grant);
      end
      drive_packet(1, 0, 100, 0, bad, es, dok);
      checks++;
      if (bad != 0 || es != 1 || dok != 1) begin
         errors++;
         $display("FAIL serr_packet: bad_cycles=%0d sync_err=%0d done_ok=%0d expected 0/1/1", bad, es, dok);
      end
   endtask

   task automatic test_junk;
      int bad, es, dok;
      req = 4'b0001;
      tick;
      m_last = rr_pick(m_last, req);
      checks++;
      if (grant !== 4'b0001) begin
         errors++;
         $display("FAIL junk_grant: grant=%b expected 0001", grant);
      end
      drive_packet(0, 5, 0, 0, bad, es, dok);
      checks++;
      if (bad != 0 || es != 0 || dok != 1) begin
         errors++;
         $display("FAIL junk_packet: bad_cycles=%0d sync_err=%0d done_ok=%0d expected 0/0/1", bad, es, dok);
      end
   endtask

   task automatic test_random;
      int exp, bad, es, dok, junk, err_at;
      for (int p = 0; p < 8; p++) begin
         req = 4'($urandom_range(1, 15));
         tick;
         exp = rr_pick(m_last, req);
         m_last = exp;
         checks++;
         if (grant !== onehot(exp) || mux_ctrl !== 2'(exp)) begin
            errors++;
            $display("FAIL rand_grant[%0d]: req=%b grant=%b mux=%0d expected channel %0d", p, req, grant, mux_ctrl, exp);
         end
         junk   = $urandom_range(0, 3);
         err_at = ($urandom_range(0, 1) == 1) ? $urandom_range(2, PKT_LEN - 1) : 0;
         // Owner's req may drop mid-packet without effect.
         req = 4'($urandom_range(0, 15));
         drive_packet(exp, junk, err_at, 30, bad, es, dok);
         checks++;
         if (bad != 0 || es != (err_at > 0 ? 1 : 0) || dok != 1) begin
            errors++;
            $display("FAIL rand_packet[%0d]: ch=%0d err_at=%0d bad_cycles=%0d sync_err=%0d done_ok=%0d",
                     p, exp, err_at, bad, es, dok);
         end
      end
   endtask

   task automatic test_reset_mid;
      int bad, es, dok;
      req = 4'b0100;
      tick;
      m_last = rr_pick(m_last, req);
      valid[2] = 1'b1;
      for (int b = 1; b < 50; b++) begin
         sync[2] = (b == 1);
         tick;
      end
      sync[2] = 1'b0;
      checks++;
      if (pkt_active !== 1'b1 || grant !== 4'b0100) begin
         errors++;
         $display("FAIL rstmid_pre: act=%b grant=%b expected 1/0100", pkt_active, grant);
      end
      rst = 1'b1;
      tick;
      checks++;
      if (mux_ctrl !== 2'd0 || grant !== 4'b0 || pkt_active !== 1'b0 ||
          pkt_done !== 1'b0 || sync_err !== 1'b0 || timeout !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_outputs: mux=%0d grant=%b act=%b done=%b err=%b to=%b expected reset values",
                  mux_ctrl, grant, pkt_active, pkt_done, sync_err, timeout);
      end
      rst = 1'b0; valid = '0; m_last = 3;
      req = 4'b1111;
      tick;
      m_last = rr_pick(m_last, req);
      checks++;
      if (grant !== 4'b0001 || m_last != 0) begin
         errors++;
         $display("FAIL rstmid_regrant: grant=%b expected 0001", grant);
      end
      drive_packet(0, 0, 0, 0, bad, es, dok);
      checks++;
      if (bad != 0 || dok != 1) begin
         errors++;
         $display("FAIL rstmid_packet: bad_cycles=%0d done_ok=%0d expected 0/1", bad, dok);
      end
   endtask

   task automatic test_stall;
      int stall_bad;
      req = 4'b1000;
      tick;
      m_last = rr_pick(m_last, req);
      checks++;
      if (grant !== 4'b1000) begin
         errors++;
         $display("FAIL stall_grant: grant=%b expected 1000", grant);
      end
      valid[3] = 1'b1;
      for (int b = 1; b <= 10; b++) begin
         sync[3] = (b == 1);
         tick;
      end
      valid[3] = 1'b0; sync[3] = 1'b0;
`ifdef SCHED_TIMEOUT_EN
      begin
         int seen;
         seen = -1;
         for (int j = 1; j <= TIMEOUT_CYC + 5; j++) begin
            noise(3);
            valid[3] = 1'b0;
            tick;
            if (timeout === 1'b1) begin
               seen = j;
               break;
            end
         end
         checks++;
         if (seen != TIMEOUT_CYC || grant !== 4'b0 || pkt_active !== 1'b0) begin
            errors++;
            $display("FAIL timeout_pulse: seen_after=%0d grant=%b expected %0d/0000", seen, grant, TIMEOUT_CYC);
         end
         valid = '0; req = 4'b1111;
         tick;
         m_last = rr_pick(m_last, req);
         checks++;
         if (grant !== 4'b0001 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL timeout_next: grant=%b timeout=%b expected 0001/0", grant, timeout);
         end
      end
`else
      stall_bad = 0;
      for (int j = 0; j < 1500; j++) begin
         noise(3);
         valid[3] = 1'b0;
         req = 4'($urandom_range(0, 15));
         tick;
         if (grant !== 4'b1000 || timeout !== 1'b0 || pkt_active !== 1'b1) stall_bad++;
      end
      checks++;
      if (stall_bad != 0) begin
         errors++;
         $display("FAIL stall_hold: bad_cycles=%0d expected 0", stall_bad);
      end
`endif
      valid = '0; sync = '0; req = '0;
      rst = 1'b1;
      tick;
      rst = 1'b0; m_last = 3;
   endtask

   initial begin
      test_reset;
      test_round_robin;
      test_back_to_back;
      test_sync_err;
      test_junk;
      test_random;
      test_reset_mid;
      test_stall;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ts_channel_scheduler.md
# ts_channel_scheduler

Packet-boundary round-robin scheduler for the four MPEG2-TS input channels. It decides which channel owns the shared output path and drives the 2-bit channel select consumed by the per-channel data/sync multiplexers. Ownership changes only between whole 188-byte packets, so the output stream is never spliced mid-packet. The block sits between the channel input stages and the output mux stage of the QoS controller.

## Interface
Parameters:
- PKT_LEN, 188, bytes per TS packet, including the sync byte.
- CNT_W, 8, byte counter width; must satisfy 2^CNT_W > PKT_LEN.
- TIMEOUT_CYC, 1024, stall limit in clocks; used only with SCHED_TIMEOUT_EN.
- TO_W, 11, stall counter width; must satisfy 2^TO_W > TIMEOUT_CYC.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  4  req[i]=1: channel i has at least one packet ready.
- valid  in  4  valid[i]=1: channel i presents a byte this cycle.
- sync  in  4  sync[i]=1: channel i's current byte is a sync byte (0x47); only meaningful with valid[i].
- mux_ctrl  out  2  selected channel index, registered.
- grant  out  4  one-hot of mux_ctrl while a channel is owned; 0 in IDLE.
- pkt_active  out  1  high in state XFER.
- pkt_done  out  1  one-cycle pulse on the last byte of a packet.
- sync_err  out  1  one-cycle pulse on unexpected sync inside a packet.
- timeout  out  1  one-cycle pulse on stall abort; tied 0 without SCHED_TIMEOUT_EN.

## Operation
- States: IDLE, WAIT_SYNC, XFER.
- Round-robin pointer `last` (2 bits) holds the most recently granted channel; reset value 3, so channel 0 wins first.
- IDLE: if req != 0, select the first i with req[i]=1, searching last+1, last+2, … modulo 4. Load mux_ctrl=i and last=i; go to WAIT_SYNC. If req == 0, hold mux_ctrl.
- WAIT_SYNC: grant asserted. Bytes with valid[sel]&~sync[sel] are ignored. On valid[sel]&sync[sel], set byte_cnt=1 and go to XFER.
- XFER: on each valid[sel], byte_cnt increments.
  - If the accepted byte is byte PKT_LEN (byte_cnt==PKT_LEN-1 before increment): pulse pkt_done, go to IDLE, clear byte_cnt.
  - If sync[sel] arrives with byte_cnt != 0 before the packet completes: pulse sync_err, restart byte_cnt=1, and stay on the same channel. The restart treats this byte as a new packet start.
- req deassertion of the owning channel during WAIT_SYNC or XFER is ignored; ownership ends only via pkt_done or timeout.
- Inputs of non-selected channels never affect state.
- Counter arithmetic is unsigned CNT_W-bit; byte_cnt never exceeds PKT_LEN-1.

## Timing
- Reset: state=IDLE, mux_ctrl=0, grant=0, last=3, byte_cnt=0, pkt_active=0, pkt_done=0, sync_err=0, timeout=0.
- Arbitration latency: req sampled in IDLE at edge N; mux_ctrl/grant valid after edge N, so state is WAIT_SYNC from cycle N+1.
- mux_ctrl is stable from grant until the return to IDLE, and in IDLE until the next grant.
- pkt_done is registered; it is high in the cycle after the last byte is accepted, coincident with state=IDLE.
- Back-to-back packets: minimum one IDLE cycle between pkt_done and the next grant. A single requesting channel is re-granted immediately.
- Packet duration: PKT_LEN valid cycles after sync at full rate. Gaps in valid stretch it with no limit unless SCHED_TIMEOUT_EN is defined.

## Configuration
- Macro: SCHED_TIMEOUT_EN.
- Defined: stall counter clears on every valid[sel] and on entry to WAIT_SYNC, and increments each cycle otherwise in WAIT_SYNC/XFER. On reaching TIMEOUT_CYC, pulse timeout, clear byte_cnt, and go to IDLE. The round-robin pointer has already advanced, so the stalled channel loses its turn.
- Undefined: no stall counter; timeout is constant 0. A stalled channel holds the output indefinitely.

## Test plan
- After reset, req=4'b1111, each channel sends 188 bytes at full rate with sync on byte 1 → grant order 0,1,2,3,0; one pkt_done per packet; one IDLE cycle between packets.
- req=4'b0100 only, two back-to-back packets → mux_ctrl=2 throughout; two pkt_done pulses; grant drops for exactly one cycle between them.
- Channel 1 granted; sync arrives at byte 100 → sync_err pulse; packet completes 187 bytes later; pkt_done then fires once.
- Channel 0 granted; non-sync bytes arrive before the first sync → ignored; byte_cnt starts at 1 on the sync; pkt_done after 188 counted bytes.
- Reset asserted mid-packet (byte 50) → next cycle all outputs at reset values; next arbitration starts at channel 0.
- With SCHED_TIMEOUT_EN: channel 3 stops valid at byte 10 → timeout pulse exactly TIMEOUT_CYC cycles after the last byte; IDLE follows; channel 0 is granted next if requesting. Without the macro, the grant is held indefinitely.
